// File: rtl/seq_pattern_detector_if.sv
// Serial-input / match-output bundle for seq_pattern_detector.
// master drives the bit stream and controls; slave is the detector.
interface seq_pattern_detector_if #(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned CNT_W = 8
);
  logic             din_valid;
  logic             din;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output din_valid, din, pat_load, pat_in, cnt_clr,
    input  match, match_cnt, armed
  );

  modport slave (
    input  din_valid, din, pat_load, pat_in, cnt_clr,
    output match, match_cnt, armed
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Sliding-window serial pattern detector with runtime pattern load and saturating match count.
// Define MATCH_REG_EN to register the match pulse one cycle after detection.
module seq_pattern_detector #(
  parameter int unsigned      PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(3'b111),
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input logic                    clk,
  input logic                    rst,
  seq_pattern_detector_if.slave  bus
);

  localparam int unsigned     FW       = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StArmed} fill_st_e;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fill_st_e         st_q, st_d;

  logic [PAT_W-1:0] window;
  logic             accept;
  logic             hit;

  assign window = {hist_q, bus.din};
  assign accept = bus.din_valid & ~bus.pat_load;
  assign hit    = accept & (st_q == StArmed) & (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (bus.pat_load) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      if (hit && !OVERLAP) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      end
    end
    // Clear beats a coincident match, so that match goes uncounted.
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    st_d = StFilling;
    if (fill_d == '0) begin
      st_d = StEmpty;
    end else if (fill_d == FILL_MAX) begin
      st_d = StArmed;
    end
  end

`ifdef MATCH_REG_EN
  logic match_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      st_q    <= StEmpty;
`ifdef MATCH_REG_EN
      match_q <= 1'b0;
`endif
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
`ifdef MATCH_REG_EN
      match_q <= hit;
`endif
    end
  end

`ifdef MATCH_REG_EN
  assign bus.match = match_q & ~rst & ~bus.pat_load;
`else
  assign bus.match = hit & ~rst;
`endif
  assign bus.match_cnt = cnt_q;
  assign bus.armed     = (st_q == StArmed);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: three instances (default, non-overlapping,
// 2-bit counter) driven by directed vectors; a monitor checks each cycle from a queue.
module tb_seq_pattern_detector;

  logic clk;
  logic rst;

  seq_pattern_detector_if #(.PAT_W(3), .CNT_W(8)) bus0 ();
  seq_pattern_detector_if #(.PAT_W(3), .CNT_W(8)) bus1 ();
  seq_pattern_detector_if #(.PAT_W(3), .CNT_W(2)) bus2 ();

  seq_pattern_detector u_def (.clk(clk), .rst(rst), .bus(bus0));
  seq_pattern_detector #(.OVERLAP(1'b0)) u_novl (.clk(clk), .rst(rst), .bus(bus1));
  seq_pattern_detector #(.CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    int    dut;
    string name;
    logic  m;
    logic  a;
    int    cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_all();
    bus0.din_valid = 0; bus0.din = 0; bus0.pat_load = 0; bus0.pat_in = '0; bus0.cnt_clr = 0;
    bus1.din_valid = 0; bus1.din = 0; bus1.pat_load = 0; bus1.pat_in = '0; bus1.cnt_clr = 0;
    bus2.din_valid = 0; bus2.din = 0; bus2.pat_load = 0; bus2.pat_in = '0; bus2.cnt_clr = 0;
  endtask

  // One clock of stimulus on one instance; expectations describe that same cycle.
  task automatic step(input int dut, input string name, input logic v, input logic d,
                      input logic em, input logic ea, input int ecnt,
                      input logic pl = 1'b0, input logic [2:0] pi = 3'b000,
                      input logic cc = 1'b0, input logic r = 1'b0);
    exp_t e;
    @(negedge clk);
    #1;
    idle_all();
    rst = r;
    case (dut)
      0: begin
        bus0.din_valid = v; bus0.din = d; bus0.pat_load = pl; bus0.pat_in = pi;
        bus0.cnt_clr = cc;
      end
      1: begin
        bus1.din_valid = v; bus1.din = d; bus1.pat_load = pl; bus1.pat_in = pi;
        bus1.cnt_clr = cc;
      end
      default: begin
        bus2.din_valid = v; bus2.din = d; bus2.pat_load = pl; bus2.pat_in = pi;
        bus2.cnt_clr = cc;
      end
    endcase
    e.dut = dut; e.name = name; e.m = em; e.a = ea; e.cnt = ecnt;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic am, aa;
    int   ac;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.dut)
          0:       begin am = bus0.match; aa = bus0.armed; ac = int'(bus0.match_cnt); end
          1:       begin am = bus1.match; aa = bus1.armed; ac = int'(bus1.match_cnt); end
          default: begin am = bus2.match; aa = bus2.armed; ac = int'(bus2.match_cnt); end
        endcase
        checks++;
        if (am !== e.m) begin
          errors++;
          $display("FAIL %s match: got %b want %b", e.name, am, e.m);
        end
        checks++;
        if (aa !== e.a) begin
          errors++;
          $display("FAIL %s armed: got %b want %b", e.name, aa, e.a);
        end
        checks++;
        if (ac != e.cnt) begin
          errors++;
          $display("FAIL %s match_cnt: got %0d want %0d", e.name, ac, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Reset state on every instance.
    step(0, "rst_def",  0, 0, 0, 0, 0);
    step(1, "rst_novl", 0, 0, 0, 0, 0);
    step(2, "rst_sat",  0, 0, 0, 0, 0);

    // 1: overlapping 111 on five ones.
    step(0, "t1_b1", 1, 1, 0, 0, 0);
    step(0, "t1_b2", 1, 1, 0, 0, 0);
    step(0, "t1_b3", 1, 1, 1, 1, 0);
    step(0, "t1_b4", 1, 1, 1, 1, 1);
    step(0, "t1_b5", 1, 1, 1, 1, 2);
    step(0, "t1_end", 0, 0, 0, 1, 3);

    // 2: non-overlapping, six ones.
    step(1, "t2_b1", 1, 1, 0, 0, 0);
    step(1, "t2_b2", 1, 1, 0, 0, 0);
    step(1, "t2_b3", 1, 1, 1, 1, 0);
    step(1, "t2_b4", 1, 1, 0, 0, 1);
    step(1, "t2_b5", 1, 1, 0, 0, 1);
    step(1, "t2_b6", 1, 1, 1, 1, 1);
    step(1, "t2_end", 0, 0, 0, 0, 2);

    // 3: gaps are transparent; 110 and 101 windows do not match.
    step(0, "t3_rst", 0, 0, 0, 1, 3, 0, 3'b000, 0, 1);
    step(0, "t3_b1", 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, "t3_gap", 0, 1, 0, 0, 0);
    step(0, "t3_b2", 1, 1, 0, 0, 0);
    step(0, "t3_b3", 1, 0, 0, 1, 0);
    step(0, "t3_gap2", 0, 1, 0, 1, 0);
    step(0, "t3_b4", 1, 1, 0, 1, 0);
    step(0, "t3_rst2", 0, 0, 0, 1, 0, 0, 3'b000, 0, 1);
    step(0, "t3_g1", 1, 1, 0, 0, 0);
    step(0, "t3_g_", 0, 0, 0, 0, 0);
    step(0, "t3_g2", 1, 1, 0, 0, 0);
    step(0, "t3_g__a", 0, 1, 0, 1, 0);
    step(0, "t3_g__b", 0, 1, 0, 1, 0);
    step(0, "t3_g3", 1, 1, 1, 1, 0);
    step(0, "t3_end", 0, 0, 0, 1, 1);

    // 4: load 101 with a would-be match on din in the load cycle.
    step(0, "t4_load", 1, 1, 0, 1, 1, 1, 3'b101);
    step(0, "t4_b1", 1, 1, 0, 0, 1);
    step(0, "t4_b2", 1, 0, 0, 0, 1);
    step(0, "t4_b3", 1, 1, 1, 1, 1);
    step(0, "t4_b4", 1, 0, 0, 1, 2);
    step(0, "t4_b5", 1, 1, 1, 1, 2);
    step(0, "t4_end", 0, 0, 0, 1, 3);

    // 5: reset masks match and restores pattern 111.
    step(0, "t5_b1", 1, 1, 0, 1, 3);
    step(0, "t5_b2", 1, 1, 0, 1, 3);
    step(0, "t5_rst", 1, 1, 0, 1, 3, 0, 3'b000, 0, 1);
    step(0, "t5_b3", 1, 1, 0, 0, 0);
    step(0, "t5_b4", 1, 1, 0, 0, 0);
    step(0, "t5_b5", 1, 1, 1, 1, 0);
    step(0, "t5_end", 0, 0, 0, 1, 1);

    // 6: 2-bit counter saturates; clear beats a coincident match.
    step(2, "t6_b1", 1, 1, 0, 0, 0);
    step(2, "t6_b2", 1, 1, 0, 0, 0);
    step(2, "t6_b3", 1, 1, 1, 1, 0);
    step(2, "t6_b4", 1, 1, 1, 1, 1);
    step(2, "t6_b5", 1, 1, 1, 1, 2);
    step(2, "t6_b6", 1, 1, 1, 1, 3);
    step(2, "t6_b7", 1, 1, 1, 1, 3);
    step(2, "t6_clr", 1, 1, 1, 1, 3, 0, 3'b000, 1);
    step(2, "t6_after", 0, 0, 0, 1, 0);
    step(2, "t6_b8", 1, 1, 1, 1, 0);
    step(2, "t6_end", 0, 0, 0, 1, 1);

    step(0, "final", 0, 0, 0, 1, 1);
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
